// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and helpers.
// Both the byte receiver and the transmitter import this package.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

  function automatic bit uart_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Received-byte bus between the UART receiver and the register interface.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] uart_rx_value;
  logic                 uart_rx_value_ready;
  logic                 uart_rx_frame_error;

  modport master (
    output uart_rx_value,
    output uart_rx_value_ready,
    output uart_rx_frame_error
  );

  modport slave (
    input uart_rx_value,
    input uart_rx_value_ready,
    input uart_rx_frame_error
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, phase reset by clear.
// Shared by the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int OVERSAMPLE    = 16
) (
    input  logic clock,
    input  logic srst,
    input  logic clear,
    output logic sample_tick
);

    localparam int DIV = uart_div(CLOCK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours, matching hardware.
    always_ff @(posedge clock) begin
        if (srst || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // After a clear the first tick lands DIV clocks later, one sample after the edge.
    assign sample_tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
// Good frames update uart_rx_value with a ready strobe; bad stop bits raise frame_error.
module uart_rx_byte
  import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int OVERSAMPLE    = 16
) (
    input  logic           clock,
    input  logic           srst,
    input  logic           rx,
    uart_rx_byte_if.master uart
);

    localparam int DIV   = uart_div(CLOCK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int CNT_W = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] SMP_LO  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_MID = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SMP_HI  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_byte: clock too slow for baud*oversample (DIV=%0d)", DIV);
    end
    if (!uart_is_pow2(OVERSAMPLE) || (OVERSAMPLE < 8)) begin : g_bad_os
        $error("uart_rx_byte: OVERSAMPLE=%0d must be a power of two >= 8", OVERSAMPLE);
    end

    logic rx_meta;
    logic rx_sync;

    uart_state_e state;
    uart_state_e state_next;

    logic                   sample_tick;
    logic [CNT_W-1:0]       sample_cnt;
    logic                   vote_a;
    logic                   vote_b;
    logic                   mid_tick;
    logic                   bit_value;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;

    logic                   start_detect;
    logic                   shift_en;
    logic                   load_value;
    logic                   ready_next;
    logic                   ferr_next;

    logic [DATA_BITS-1:0]   value_q;
    logic                   ready_q;
    logic                   ferr_q;

    // Idle-high reset value keeps reset release from looking like a start edge.
    always_ff @(posedge clock) begin
        if (srst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_baud_tick #(
        .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
        .BAUD_RATE     (BAUD_RATE),
        .OVERSAMPLE    (OVERSAMPLE)
    ) u_baud_tick (
        .clock       (clock),
        .srst        (srst),
        .clear       (start_detect),
        .sample_tick (sample_tick)
    );

    // The detecting sample is sample 0 of the start bit, so counting resumes at 1.
    always_ff @(posedge clock) begin
        if (srst) begin
            sample_cnt <= '0;
        end else if (start_detect) begin
            sample_cnt <= CNT_W'(1);
        end else if (sample_tick && (state inside {START, DATA, STOP})) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // NOTE: pure datapath registers (votes, shift register) carry no reset; the
    // FSM never consumes them before overwriting them in the current frame.
    always_ff @(posedge clock) begin
        if (sample_tick && (sample_cnt == SMP_LO))  vote_a <= rx_sync;
        if (sample_tick && (sample_cnt == SMP_MID)) vote_b <= rx_sync;
        if (shift_en) shift_reg <= {bit_value, shift_reg[DATA_BITS-1:1]};
    end

    assign mid_tick  = sample_tick && (sample_cnt == SMP_HI);
    assign bit_value = majority3(vote_a, vote_b, rx_sync);

    always_ff @(posedge clock) begin
        if (srst || start_detect) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        start_detect = 1'b0;
        shift_en     = 1'b0;
        load_value   = 1'b0;
        ready_next   = 1'b0;
        ferr_next    = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next   = START;
                    start_detect = 1'b1;
                end
            end
            START: begin
                if (mid_tick) begin
                    state_next = bit_value ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit of slack for the next start edge.
                if (mid_tick) begin
                    if (bit_value) begin
                        load_value = 1'b1;
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            value_q <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (load_value) value_q <= shift_reg;
            ready_q <= ready_next;
            ferr_q  <= ferr_next;
        end
    end

    assign uart.uart_rx_value       = value_q;
    assign uart.uart_rx_value_ready = ready_q;
    assign uart.uart_rx_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: table of frames plus
// hand-written back-to-back, glitch, break and mid-frame reset sequences.
module tb_uart_rx_byte;

    logic clock = 1'b0;
    logic srst;
    logic rx;

    uart_rx_byte_if bus ();

    uart_rx_byte #(
        .CLOCK_FREQ_HZ (1_843_200),
        .BAUD_RATE     (115_200),
        .OVERSAMPLE    (16)
    ) dut (
        .clock (clock),
        .srst  (srst),
        .rx    (rx),
        .uart  (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int ready_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int wide_cnt  = 0;
    logic prev_ready = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clock) begin
        if (bus.uart_rx_value_ready === 1'b1) begin
            ready_cnt <= ready_cnt + 1;
            rx_q.push_back(bus.uart_rx_value);
        end
        if (bus.uart_rx_frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.uart_rx_value_ready === 1'b1 && bus.uart_rx_frame_error === 1'b1)
            both_cnt <= both_cnt + 1;
        if (bus.uart_rx_value_ready === 1'b1 && prev_ready === 1'b1)
            wide_cnt <= wide_cnt + 1;
        prev_ready <= bus.uart_rx_value_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int period, input logic stop_bit);
        rx = 1'b0;
        tick_n(period);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_n(period);
        end
        rx = stop_bit;
        tick_n(period);
        if (!stop_bit) tick_n(40);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop_bit;
        int         exp_ready;
        int         exp_ferr;
        logic [7:0] exp_value;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int r0;
        int f0;
        int q0;

        vecs[0] = '{8'h55, 16, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hA5, 16, 1'b1, 1, 0, 8'hA5};
        vecs[2] = '{8'h00, 16, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 16, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{8'h3C, 16, 1'b0, 0, 1, 8'hFF};
        vecs[5] = '{8'h12, 16, 1'b1, 1, 0, 8'h12};
        vecs[6] = '{8'hC3, 15, 1'b1, 1, 0, 8'hC3};
        vecs[7] = '{8'hC3, 17, 1'b1, 1, 0, 8'hC3};
        vecs[8] = '{8'h80, 16, 1'b1, 1, 0, 8'h80};

        rx   = 1'b1;
        srst = 1'b1;
        @(posedge clock);
        #1;
        tick_n(3);
        check("reset_value", 32'(bus.uart_rx_value), 32'h00);
        check("reset_ready", 32'(bus.uart_rx_value_ready), 32'h0);
        check("reset_ferr", 32'(bus.uart_rx_frame_error), 32'h0);
        srst = 1'b0;
        tick_n(5);

        for (int v = 0; v < 9; v++) begin
            r0 = ready_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].period, vecs[v].stop_bit);
            tick_n(30);
            check($sformatf("vec%0d_ready_pulses", v), 32'(ready_cnt - r0), 32'(vecs[v].exp_ready));
            check($sformatf("vec%0d_ferr_pulses", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_value", v), 32'(bus.uart_rx_value), 32'(vecs[v].exp_value));
            if (vecs[v].exp_ready == 1 && rx_q.size() > 0)
                check($sformatf("vec%0d_strobed_value", v), 32'(rx_q[$]), 32'(vecs[v].exp_value));
        end

        // Back-to-back frames with no idle gap between stop and next start.
        r0 = ready_cnt;
        q0 = rx_q.size();
        send_frame(8'h53, 16, 1'b1);
        send_frame(8'h03, 16, 1'b1);
        send_frame(8'h52, 16, 1'b1);
        tick_n(30);
        check("b2b_ready_pulses", 32'(ready_cnt - r0), 32'd3);
        if (rx_q.size() >= q0 + 3) begin
            check("b2b_byte0", 32'(rx_q[q0]), 32'h53);
            check("b2b_byte1", 32'(rx_q[q0 + 1]), 32'h03);
            check("b2b_byte2", 32'(rx_q[q0 + 2]), 32'h52);
        end else begin
            check("b2b_queue_depth", 32'(rx_q.size() - q0), 32'd3);
        end

        // Short low glitch on an idle line must be rejected silently.
        r0 = ready_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick_n(3);
        rx = 1'b1;
        tick_n(40);
        check("glitch_ready_pulses", 32'(ready_cnt - r0), 32'd0);
        check("glitch_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'hA5, 16, 1'b1);
        tick_n(30);
        check("after_glitch_ready", 32'(ready_cnt - r0), 32'd1);
        check("after_glitch_value", 32'(bus.uart_rx_value), 32'hA5);

        // Reset during data bit 4 of 0xFF discards the frame and clears the value.
        r0 = ready_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick_n(16);
        rx = 1'b1;
        tick_n(16 * 4 + 8);
        srst = 1'b1;
        tick_n(1);
        srst = 1'b0;
        tick_n(200);
        check("srst_ready_pulses", 32'(ready_cnt - r0), 32'd0);
        check("srst_ferr_pulses", 32'(ferr_cnt - f0), 32'd0);
        check("srst_value", 32'(bus.uart_rx_value), 32'h00);
        send_frame(8'h81, 16, 1'b1);
        tick_n(30);
        check("after_srst_ready", 32'(ready_cnt - r0), 32'd1);
        check("after_srst_value", 32'(bus.uart_rx_value), 32'h81);

        check("ready_and_ferr_overlap", 32'(both_cnt), 32'd0);
        check("ready_wider_than_1", 32'(wide_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
